// File: rtl/key_pulse_conditioner.sv
`default_nettype none
// key_pulse_conditioner: per-key synchroniser, debounce filter and press/release/auto-repeat
// pulse generator, with optional single-owner arbitration between keys.
// Rev 1.0
module key_pulse_conditioner #(
   parameter int NUM_KEYS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int ACTIVE_LOW_KEYS = 1,
   parameter int EXCLUSIVE       = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NUM_KEYS-1:0] key_raw_i,
   input  logic [NUM_KEYS-1:0] repeat_en_i,
   output logic [NUM_KEYS-1:0] press_pulse_o,
   output logic [NUM_KEYS-1:0] release_pulse_o,
   output logic [NUM_KEYS-1:0] held_o
);
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RC_W    = $clog2(RPT_MAX + 1);
   localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam logic [NUM_KEYS-1:0] IDLE_LVL  = {NUM_KEYS{ACTIVE_LOW_KEYS != 0}};
   localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0]     DLY_LAST  = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0]     RATE_LAST = RC_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } state_e;

   logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
   logic [NUM_KEYS-1:0] pressed;
   logic [NUM_KEYS-1:0] db_q, db_d;
   logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
   logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];
   state_e              state_q [NUM_KEYS];
   state_e              state_d [NUM_KEYS];
   logic [RC_W-1:0]     rcnt_q [NUM_KEYS];
   logic [RC_W-1:0]     rcnt_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] blocked_q, blocked_d;
   logic [NUM_KEYS-1:0] press_d, release_d, held_d;
   logic                owner_vld_q, owner_vld_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic                grant_taken;

   // Sync chain resets to the idle pin level so reset exit never looks like an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IDLE_LVL;
      end else begin
         sync_q[0] <= key_raw_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign pressed = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

   always_comb begin
      db_d = db_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         db_cnt_d[i] = '0;
         if (pressed[i] != db_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) db_d[i] = ~db_q[i];
            else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      blocked_d   = blocked_q;
      press_d     = '0;
      release_d   = '0;
      held_d      = '0;
      owner_vld_d = owner_vld_q;
      owner_d     = owner_q;
      grant_taken = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         state_d[i] = state_q[i];
         rcnt_d[i]  = rcnt_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (!db_q[i]) begin
                  blocked_d[i] = 1'b0;
               end else if (!blocked_q[i]) begin
                  // Scan order gives the lowest index priority on simultaneous rises.
                  if (EXCLUSIVE == 0 || (!owner_vld_q && !grant_taken)) begin
                     state_d[i] = S_DELAY;
                     rcnt_d[i]  = '0;
                     press_d[i] = 1'b1;
                     if (EXCLUSIVE != 0) begin
                        grant_taken = 1'b1;
                        owner_vld_d = 1'b1;
                        owner_d     = IDX_W'(i);
                     end
                  end else begin
                     blocked_d[i] = 1'b1;
                  end
               end
            end
            S_DELAY, S_REPEAT: begin
               if (!db_q[i]) begin
                  state_d[i]   = S_IDLE;
                  rcnt_d[i]    = '0;
                  release_d[i] = 1'b1;
                  if (owner_vld_q && owner_q == IDX_W'(i)) owner_vld_d = 1'b0;
               end else if (!repeat_en_i[i]) begin
                  rcnt_d[i] = '0;
               end else if (rcnt_q[i] == ((state_q[i] == S_DELAY) ? DLY_LAST : RATE_LAST)) begin
                  state_d[i] = S_REPEAT;
                  rcnt_d[i]  = '0;
                  press_d[i] = 1'b1;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + 1'b1;
               end
            end
            default: state_d[i] = S_IDLE;
         endcase
         held_d[i] = (state_d[i] != S_IDLE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         db_q            <= '0;
         blocked_q       <= '0;
         owner_vld_q     <= 1'b0;
         owner_q         <= '0;
         press_pulse_o   <= '0;
         release_pulse_o <= '0;
         held_o          <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            db_cnt_q[i] <= '0;
            state_q[i]  <= S_IDLE;
            rcnt_q[i]   <= '0;
         end
      end else begin
         db_q            <= db_d;
         blocked_q       <= blocked_d;
         owner_vld_q     <= owner_vld_d;
         owner_q         <= owner_d;
         press_pulse_o   <= press_d;
         release_pulse_o <= release_d;
         held_o          <= held_d;
         for (int i = 0; i < NUM_KEYS; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
            state_q[i]  <= state_d[i];
            rcnt_q[i]   <= rcnt_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// tb_key_pulse_conditioner: randomized and directed stimulus, scoreboard against a behavioural model.
// Rev 1.0
module tb_key_pulse_conditioner;
   localparam int NK   = 4;
   localparam int S    = 2;
   localparam int D    = 4;
   localparam int RD   = 10;
   localparam int RR   = 3;
   localparam int EXCL = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NK-1:0] key_raw = '1;
   logic [NK-1:0] repeat_en = '0;
   logic [NK-1:0] press_o, rel_o, held_o;
   logic [NK-1:0] raw6 = '0;
   logic [NK-1:0] rep6 = '0;
   logic [NK-1:0] press6, rel6, held6;

   always #5 clk = ~clk;

   key_pulse_conditioner #(
      .NUM_KEYS(NK), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR), .ACTIVE_LOW_KEYS(1), .EXCLUSIVE(EXCL)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .key_raw_i(key_raw), .repeat_en_i(repeat_en),
      .press_pulse_o(press_o), .release_pulse_o(rel_o), .held_o(held_o)
   );

   key_pulse_conditioner #(
      .NUM_KEYS(NK), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR), .ACTIVE_LOW_KEYS(0), .EXCLUSIVE(0)
   ) u_dut6 (
      .clk_i(clk), .rst_ni(rst_n), .key_raw_i(raw6), .repeat_en_i(rep6),
      .press_pulse_o(press6), .release_pulse_o(rel6), .held_o(held6)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int            cyc;
      logic [NK-1:0] prs;
      logic [NK-1:0] rel;
   } ev_t;
   ev_t sb[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: pin history delayed S cycles, run-length debounce, deadline-based repeat.
   logic [NK-1:0] m_hist [S];
   int            m_run [NK];
   bit            m_db [NK];
   bit            m_act [NK];
   bit            m_blk [NK];
   bit            m_rep [NK];
   int            m_due [NK];
   int            m_owner = -1;
   logic [NK-1:0] m_held = '0;

   initial begin : model
      logic [NK-1:0] pr, prs, rel;
      int            own0;
      bit            gnt;
      ev_t           e;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            for (int k = 0; k < S; k++) m_hist[k] = '1;
            for (int i = 0; i < NK; i++) begin
               m_run[i] = 0; m_db[i] = 0; m_act[i] = 0; m_blk[i] = 0; m_rep[i] = 0; m_due[i] = 0;
            end
            m_owner = -1;
            m_held  = '0;
         end else begin
            pr = ~m_hist[S-1];
            for (int k = S-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = key_raw;
            prs  = '0;
            rel  = '0;
            own0 = m_owner;
            gnt  = 0;
            for (int i = 0; i < NK; i++) begin
               if (m_act[i]) begin
                  if (!m_db[i]) begin
                     rel[i]   = 1'b1;
                     m_act[i] = 0;
                     if (m_owner == i) m_owner = -1;
                  end else if (!repeat_en[i]) begin
                     m_due[i] = cyc + (m_rep[i] ? RR : RD);
                  end else if (cyc == m_due[i]) begin
                     prs[i]   = 1'b1;
                     m_rep[i] = 1;
                     m_due[i] = cyc + RR;
                  end
               end else if (m_db[i] && !m_blk[i]) begin
                  if (EXCL == 0 || (own0 < 0 && !gnt)) begin
                     prs[i]   = 1'b1;
                     m_act[i] = 1;
                     m_rep[i] = 0;
                     m_due[i] = cyc + RD;
                     if (EXCL != 0) begin gnt = 1; m_owner = i; end
                  end else begin
                     m_blk[i] = 1;
                  end
               end else if (!m_db[i]) begin
                  m_blk[i] = 0;
               end
            end
            for (int i = 0; i < NK; i++) begin
               if (pr[i] != m_db[i]) begin
                  m_run[i]++;
                  if (m_run[i] == D) begin m_db[i] = !m_db[i]; m_run[i] = 0; end
               end else begin
                  m_run[i] = 0;
               end
               m_held[i] = m_act[i];
            end
            if ((prs | rel) != '0) begin
               e.cyc = cyc; e.prs = prs; e.rel = rel;
               sb.push_back(e);
            end
         end
      end
   end

   int press_cnt [NK] = '{default: 0};
   int rel_cnt   [NK] = '{default: 0};
   int last_press[NK] = '{default: -1};
   int last_rel  [NK] = '{default: -1};
   int last6p    [NK] = '{default: -1};
   int last6r    [NK] = '{default: -1};

   initial begin : monitor
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < NK; i++) begin
               if (press_o[i]) begin press_cnt[i]++; last_press[i] = cyc; end
               if (rel_o[i])   begin rel_cnt[i]++;   last_rel[i]   = cyc; end
               if (press6[i])  last6p[i] = cyc;
               if (rel6[i])    last6r[i] = cyc;
            end
            chk("press_release_overlap", int'(press_o & rel_o), 0);
            chk("held", int'(held_o), int'(m_held));
            if ((press_o | rel_o) != '0) begin
               if (sb.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_pulse: press %h release %h at cycle %0d, none expected",
                           press_o, rel_o, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("pulse_cycle", cyc, e.cyc);
                  chk("press_vec", int'(press_o), int'(e.prs));
                  chk("release_vec", int'(rel_o), int'(e.rel));
               end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
               e = sb.pop_front();
               n_checks++; n_fail++;
               $display("FAIL missed_pulse: outputs quiet, expected press %h release %h at cycle %0d",
                        e.prs, e.rel, e.cyc);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin : stim
      int t0, t1, c0, c1, found;
      idle(3);
      chk("reset_press", int'(press_o), 0);
      chk("reset_release", int'(rel_o), 0);
      chk("reset_held", int'(held_o), 0);
      #1 rst_n = 1'b1;
      idle(5);

      // single press/release, no repeat
      t0 = cyc; key_raw[1] = 1'b0;
      idle(20); key_raw[1] = 1'b1;
      idle(12);
      chk("t1_press_cycle", last_press[1], t0 + 7);
      chk("t1_release_cycle", last_rel[1], t0 + 27);
      chk("t1_press_count", press_cnt[1], 1);

      // bouncing key never accepted
      c0 = press_cnt[0]; c1 = rel_cnt[0];
      repeat (10) begin
         key_raw[0] = 1'b0; idle(3);
         key_raw[0] = 1'b1; idle(1);
      end
      idle(10);
      chk("t2_bounce_press", press_cnt[0], c0);
      chk("t2_bounce_release", rel_cnt[0], c1);

      // auto-repeat, enable dropped mid-stream
      c0 = press_cnt[2]; t0 = cyc;
      key_raw[2] = 1'b0; repeat_en[2] = 1'b1;
      idle(21); repeat_en[2] = 1'b0;
      idle(9);
      chk("t3_repeat_count", press_cnt[2] - c0, 3);
      chk("t3_last_repeat", last_press[2], t0 + 20);
      key_raw[2] = 1'b1;
      idle(12);

      // exclusive ownership and blocked key
      c0 = press_cnt[3]; t0 = cyc;
      key_raw[1] = 1'b0; key_raw[3] = 1'b0;
      idle(15);
      chk("t4_owner_press", last_press[1], t0 + 7);
      chk("t4_blocked_press", press_cnt[3], c0);
      key_raw[1] = 1'b1;
      idle(20);
      chk("t4_no_hidden_press", press_cnt[3], c0);
      chk("t4_blocked_not_held", int'(held_o[3]), 0);
      key_raw[3] = 1'b1;
      idle(12);
      t1 = cyc; key_raw[3] = 1'b0;
      idle(10);
      chk("t4_repress", last_press[3], t1 + 7);
      key_raw[3] = 1'b1;
      idle(12);

      // random key activity
      repeat (500) begin
         @(negedge clk);
         for (int i = 0; i < NK; i++) begin
            if ($urandom_range(0, 9) == 0)  key_raw[i]   = ~key_raw[i];
            if ($urandom_range(0, 29) == 0) repeat_en[i] = ~repeat_en[i];
         end
      end
      key_raw = '1; repeat_en = '0;
      idle(20);

      // reset while repeating, key held through reset
      key_raw[2] = 1'b0; repeat_en[2] = 1'b1;
      idle(25);
      c1 = rel_cnt[2];
      #1 rst_n = 1'b0;
      #1;
      chk("t5_reset_press", int'(press_o), 0);
      chk("t5_reset_release", int'(rel_o), 0);
      chk("t5_reset_held", int'(held_o), 0);
      idle(3);
      #1 rst_n = 1'b1;
      t0 = cyc; found = -1;
      for (int k = 0; k < 20 && found < 0; k++) begin
         @(negedge clk);
         if (press_o[2]) found = cyc;
      end
      chk("t5_press_after_reset", found, t0 + 7);
      chk("t5_no_release", rel_cnt[2], c1);
      key_raw[2] = 1'b1; repeat_en[2] = 1'b0;
      idle(12);

      // active-high pins, single-cycle debounce
      t0 = cyc; raw6[0] = 1'b1;
      idle(8);
      chk("t6_press_cycle", last6p[0], t0 + 4);
      chk("t6_held", int'(held6[0]), 1);
      raw6[0] = 1'b0;
      idle(6);
      t1 = cyc; raw6[1] = 1'b1;
      idle(1); raw6[1] = 1'b0;
      idle(8);
      chk("t6_glitch_press", last6p[1], t1 + 4);
      chk("t6_glitch_release", last6r[1], t1 + 5);

      idle(2);
      while (sb.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL missed_pulse_at_end: expected event at cycle %0d never seen", sb[0].cyc);
         void'(sb.pop_front());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
